// File: rtl/seven_segment_scan.sv
`default_nettype none
// ============================================================================
// seven_segment_scan : multiplexed hex display scanner with frame-synced loads
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits. Rev 1.0
// ============================================================================
module seven_segment_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic [4*DIGITS-1:0] inum,
  input  logic [DIGITS-1:0]   idp,
  input  logic                iload,
  input  logic                ien,
  output logic [7:0]          oseg,
  output logic [DIGITS-1:0]   odig
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] stg_num_q, stg_num_d, sh_num_q, sh_num_d;
  logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, sh_dp_q, sh_dp_d;
  logic                pend_q, pend_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;

  logic                tick, boundary;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [6:0]          seg7;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib = sh_num_q[4*k +: 4];
        cur_dp  = sh_dp_q[k];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_cur;
  logic lz_run;

  // A digit is blanked only while it and every more-significant digit are zero.
  always_comb begin
    lz_cur = 1'b0;
    lz_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz_run = lz_run && (sh_num_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) lz_cur = lz_run;
    end
  end

  assign seg7 = lz_cur ? 7'h7F : ~hex7(cur_nib);
`else
  assign seg7 = ~hex7(cur_nib);
`endif

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    stg_num_d = stg_num_q;
    stg_dp_d  = stg_dp_q;
    sh_num_d  = sh_num_q;
    sh_dp_d   = sh_dp_q;
    pend_d    = pend_q;
    if (iload) begin
      stg_num_d = inum;
      stg_dp_d  = idp;
      pend_d    = 1'b1;
    end
    // The shadow only moves at a frame boundary; a coincident load bypasses staging.
    if (boundary) begin
      if (iload) begin
        sh_num_d = inum;
        sh_dp_d  = idp;
      end else if (pend_q) begin
        sh_num_d = stg_num_q;
        sh_dp_d  = stg_dp_q;
      end
      pend_d = 1'b0;
    end

    seg_d = 8'hFF;
    dig_d = '1;
    if (ien && !(presc_q < BLANK_END)) begin
      seg_d = {~cur_dp, seg7};
      dig_d = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      stg_num_q <= '0;
      stg_dp_q  <= '0;
      sh_num_q  <= '0;
      sh_dp_q   <= '0;
      pend_q    <= 1'b0;
      seg_q     <= 8'hFF;
      dig_q     <= '1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      stg_num_q <= stg_num_d;
      stg_dp_q  <= stg_dp_d;
      sh_num_q  <= sh_num_d;
      sh_dp_q   <= sh_dp_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  assign oseg = seg_q;
  assign odig = dig_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
`default_nettype none
// tb_seven_segment_scan : directed checks of scan order, frame-synced loads,
// bypass, leading-zero blanking, enable gating and reset abort.
module tb_seven_segment_scan;

  logic        iclk;
  logic        irst;
  logic [15:0] inum;
  logic [3:0]  idp;
  logic        iload;
  logic        ien;
  logic [7:0]  oseg;
  logic [3:0]  odig;

  int vectors    = 0;
  int miscompares = 0;
  int k          = 0;

  logic [3:0] dig_seq [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  seven_segment_scan #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .iclk (iclk),
    .irst (irst),
    .inum (inum),
    .idp  (idp),
    .iload(iload),
    .ien  (ien),
    .oseg (oseg),
    .odig (odig)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
    k++;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++;
      if (oseg !== 8'hFF || odig !== 4'hF) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d oseg=%h odig=%h required oseg=ff odig=f", n, oseg, odig);
      end
    end
    irst = 1'b0;
    k = 0;
    step();
    vectors++;
    if (oseg !== 8'hFF || odig !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_release_blank oseg=%h odig=%h required oseg=ff odig=f", oseg, odig);
    end
    step();
    vectors++;
    if (oseg !== 8'hC0 || odig !== 4'hE) begin
      miscompares++;
      $display("FAIL reset_release_digit0 oseg=%h odig=%h required oseg=c0 odig=e", oseg, odig);
    end
  endtask

  task automatic test_free_run();
    int s;
    logic [7:0] exp_seg;
    for (int n = 0; n < 18; n++) begin
      step();
      s = (k - 1) % 16;
      exp_seg = (s % 4 == 0) ? 8'hFF : 8'hC0;
      vectors++;
      if (odig !== dig_seq[s] || oseg !== exp_seg) begin
        miscompares++;
        $display("FAIL free_run k=%0d odig=%h oseg=%h required odig=%h oseg=%h", k, odig, oseg, dig_seq[s], exp_seg);
      end
    end
  endtask

  task automatic test_load_midframe();
    int s;
    logic [7:0] exp_seg;
    logic [7:0] seg_new [4];
    seg_new = '{8'h0E, 8'h88, 8'hA4, 8'hF9};
    while (k < 40) begin
      iload = 1'b0;
      if (k == 20) begin iload = 1'b1; inum = 16'h9999; idp = 4'b0000; end
      if (k == 24) begin iload = 1'b1; inum = 16'h12AF; idp = 4'b0001; end
      step();
      s = (k - 1) % 16;
      exp_seg = (s % 4 == 0) ? 8'hFF : ((k <= 32) ? 8'hC0 : seg_new[s / 4]);
      vectors++;
      if (odig !== dig_seq[s] || oseg !== exp_seg) begin
        miscompares++;
        $display("FAIL load_midframe k=%0d odig=%h oseg=%h required odig=%h oseg=%h", k, odig, oseg, dig_seq[s], exp_seg);
      end
    end
    iload = 1'b0;
  endtask

  task automatic test_back_to_back_bypass();
    int s;
    logic [7:0] exp_seg;
    logic [7:0] seg_old [4];
    seg_old = '{8'h0E, 8'h88, 8'hA4, 8'hF9};
    while (k < 52) begin
      iload = 1'b0;
      if (k == 40) begin iload = 1'b1; inum = 16'h7777; idp = 4'b0000; end
      if (k == 47) begin iload = 1'b1; inum = 16'h3333; idp = 4'b0000; end
      step();
      s = (k - 1) % 16;
      exp_seg = (s % 4 == 0) ? 8'hFF : ((k <= 48) ? seg_old[s / 4] : 8'hB0);
      vectors++;
      if (odig !== dig_seq[s] || oseg !== exp_seg) begin
        miscompares++;
        $display("FAIL bypass k=%0d odig=%h oseg=%h required odig=%h oseg=%h", k, odig, oseg, dig_seq[s], exp_seg);
      end
    end
    iload = 1'b0;
  endtask

  task automatic test_leading_zero();
    int s;
    logic [7:0] exp_seg;
    logic [7:0] seg_lz [4];
    seg_lz = '{8'h92, LZ, LZ, LZ};
    while (k < 80) begin
      iload = 1'b0;
      if (k == 52) begin iload = 1'b1; inum = 16'h0005; idp = 4'b0000; end
      step();
      s = (k - 1) % 16;
      exp_seg = (s % 4 == 0) ? 8'hFF : ((k <= 64) ? 8'hB0 : seg_lz[s / 4]);
      vectors++;
      if (odig !== dig_seq[s] || oseg !== exp_seg) begin
        miscompares++;
        $display("FAIL leading_zero k=%0d odig=%h oseg=%h required odig=%h oseg=%h", k, odig, oseg, dig_seq[s], exp_seg);
      end
    end
    iload = 1'b0;
  endtask

  task automatic test_enable();
    int s;
    logic [7:0] exp_seg;
    logic [3:0] exp_dig;
    logic [7:0] seg_lz [4];
    seg_lz = '{8'h92, LZ, LZ, LZ};
    while (k < 98) begin
      if (k == 84) ien = 1'b0;
      if (k == 94) ien = 1'b1;
      step();
      s = (k - 1) % 16;
      if (k >= 85 && k <= 94) begin
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
      end else begin
        exp_seg = (s % 4 == 0) ? 8'hFF : seg_lz[s / 4];
        exp_dig = dig_seq[s];
      end
      vectors++;
      if (odig !== exp_dig || oseg !== exp_seg) begin
        miscompares++;
        $display("FAIL enable k=%0d odig=%h oseg=%h required odig=%h oseg=%h", k, odig, oseg, exp_dig, exp_seg);
      end
    end
  endtask

  task automatic test_reset_midload();
    int s;
    logic [7:0] exp_seg;
    iload = 1'b1; inum = 16'h8888; idp = 4'b1111;
    step();
    vectors++;
    if (odig !== 4'hE || oseg !== 8'h92) begin
      miscompares++;
      $display("FAIL pre_reset k=%0d odig=%h oseg=%h required odig=e oseg=92", k, odig, oseg);
    end
    irst = 1'b1; iload = 1'b1; inum = 16'h1234; idp = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      step();
      iload = 1'b0;
      vectors++;
      if (oseg !== 8'hFF || odig !== 4'hF) begin
        miscompares++;
        $display("FAIL midscan_reset cyc=%0d oseg=%h odig=%h required oseg=ff odig=f", n, oseg, odig);
      end
    end
    irst = 1'b0;
    k = 0;
    while (k < 20) begin
      step();
      s = (k - 1) % 16;
      exp_seg = (s % 4 == 0) ? 8'hFF : 8'hC0;
      vectors++;
      if (odig !== dig_seq[s] || oseg !== exp_seg) begin
        miscompares++;
        $display("FAIL reset_discard k=%0d odig=%h oseg=%h required odig=%h oseg=%h", k, odig, oseg, dig_seq[s], exp_seg);
      end
    end
  endtask

  initial begin
    irst  = 1'b1;
    ien   = 1'b1;
    iload = 1'b0;
    inum  = 16'h0000;
    idp   = 4'b0000;
    test_reset();
    test_free_run();
    test_load_midframe();
    test_back_to_back_bypass();
    test_leading_zero();
    test_enable();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-003 Parameter BLANK_CYC, default 2: anti-ghost blank cycles at the start of each slot, range 0..SCAN_DIV-1.
REQ-004 iclk  input  1  the single clock; all logic is on its rising edge.
REQ-005 irst  input  1  reset, synchronous and active-high.
REQ-006 inum  input  4*DIGITS  hex nibble per digit; nibble k = inum[4k+3:4k]; digit 0 is the rightmost, least significant digit.
REQ-007 idp  input  DIGITS  decimal point request per digit, active-high.
REQ-008 iload  input  1  single-cycle strobe that captures inum/idp into the staging registers.
REQ-009 ien  input  1  display enable, active-high.
REQ-010 oseg  output  8  registered segment drive, active-low: [0]=a .. [6]=g, [7]=dp.
REQ-011 odig  output  DIGITS  registered digit select, active-low, one-hot-low while a digit is lit.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 every cycle and wraps to 0; tick = (prescaler==SCAN_DIV-1).
REQ-013 On tick, the digit index increments, wrapping from DIGITS-1 to 0; frame boundary = tick while index==DIGITS-1.
REQ-014 On iload, inum/idp are captured into staging and a pending flag is set; a later iload before the boundary overwrites staging.
REQ-015 At a frame boundary with pending set, staging is copied to the display shadow and pending is cleared; the shadow never changes mid-frame.
REQ-016 When iload coincides with a frame boundary, the same-cycle inum/idp go directly to the shadow (bypass) and pending ends clear.
REQ-017 Decode is active-high a..g hex before inversion: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; oseg[6:0] is its inverse.
REQ-018 oseg[7] = ~shadow_dp[index].
REQ-019 Outputs are registered with one cycle of latency from the (prescaler, index, shadow) state.
REQ-020 While prescaler < BLANK_CYC, odig is all ones and oseg is 8'hFF.
REQ-021 Otherwise odig has only bit[index] low and oseg carries the decode of digit index.
REQ-022 When ien=0, oseg=8'hFF and odig is all ones on the next cycle; prescaler, index and load logic keep running.

Reset
REQ-023 While irst=1: prescaler=0, index=0, staging=0, shadow=0, pending=0, oseg=8'hFF, odig all ones.
REQ-024 irst asserted mid-scan or mid-load aborts the operation and discards pending data; irst has priority over iload.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: a digit k>0 whose nibble and all more-significant shadow nibbles are 0 drives oseg[6:0]=7'h7F (dp per REQ-018) with its odig still asserted; digit 0 is never blanked.
REQ-026 Macro LEADING_ZERO_BLANK_EN undefined: all digits are decoded per REQ-017 and the blanking logic is absent.

Verification (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1)
REQ-027 Hold irst for 3 cycles with ien=1 -> oseg=8'hFF and odig=4'hF throughout; then odig=4'hE with oseg=8'hC0 (digit "0", dp off) within 3 cycles of release.
REQ-028 Free run -> odig repeats 1111,1110x3, 1111,1101x3, 1111,1011x3, 1111,0111x3 and wraps to digit 0.
REQ-029 iload inum=16'h12AF, idp=4'b0001 mid-frame -> old digits persist until the boundary; next frame digit0 oseg=8'h0E and digit3 oseg=8'hF9.
REQ-030 iload 16'h3333 on the boundary cycle -> the following frame shows "3" (8'hB0) on all digits and pending reads clear.
REQ-031 Shadow 16'h0005, idp=0: with the macro, digits 3..1 show oseg=8'hFF and digit 0 shows 8'h92; without it, digits 3..1 show 8'hC0.
REQ-032 Drop ien for 10 cycles -> all outputs inactive on the next cycle; on return the scan resumes at the free-running index, not at digit 0.
